control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 90 +++++++++
 rtl/cu_microrom.sv | 86 ++++++++
 rtl/control_unit.sv | 119 +++++++++++
 tb/tb_control_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: micro-op bit indices, opcodes,
// state encoding and small decode helpers.
package cu_pkg;

  localparam int CW = 32;

  localparam int B_PC_MAR     = 0;
  localparam int B_PC_INC     = 1;
  localparam int B_MEM_MBR    = 2;
  localparam int B_MBR_IR     = 3;
  localparam int B_IRADDR_MAR = 4;
  localparam int B_MBR_BR     = 5;
  localparam int B_ACC_MBR    = 6;
  localparam int B_MBR_MEM    = 7;
  localparam int B_IRADDR_PC  = 8;
  localparam int B_BR_ACC     = 9;
  localparam int B_MPY_HI_MR  = 16;
  localparam int B_ADD        = 22;
  localparam int B_SUB        = 23;
  localparam int B_AND        = 24;
  localparam int B_OR         = 25;
  localparam int B_NOT        = 26;
  localparam int B_SHL        = 27;
  localparam int B_SHR        = 28;
  localparam int B_MPY_LO_ACC = 29;
  localparam int B_SAL        = 30;
  localparam int B_SAR        = 31;

  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_MPY    = 8'h08;
  localparam logic [7:0] OP_AND    = 8'h0A;
  localparam logic [7:0] OP_OR     = 8'h0B;
  localparam logic [7:0] OP_NOT    = 8'h0C;
  localparam logic [7:0] OP_SHR    = 8'h0D;
  localparam logic [7:0] OP_SHL    = 8'h0E;
  localparam logic [7:0] OP_SAR    = 8'h0F;
  localparam logic [7:0] OP_SAL    = 8'h10;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH0 = 4'd1,
    FETCH1 = 4'd2,
    FETCH2 = 4'd3,
    EXEC0  = 4'd4,
    EXEC1  = 4'd5,
    EXEC2  = 4'd6,
    EXEC3  = 4'd7,
    HALT   = 4'd8
  } state_t;

  function automatic logic [CW-1:0] bit_word(input int idx);
    return 32'd1 << idx;
  endfunction

  localparam logic [CW-1:0] W_FETCH0 = 32'd1 << B_PC_MAR;
  localparam logic [CW-1:0] W_FETCH1 = (32'd1 << B_PC_INC) | (32'd1 << B_MEM_MBR);
  localparam logic [CW-1:0] W_FETCH2 = 32'd1 << B_MBR_IR;

  function automatic logic [1:0] step_of(input state_t s);
    case (s)
      EXEC1:   return 2'd1;
      EXEC2:   return 2'd2;
      EXEC3:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic state_t exec_state(input logic [1:0] step);
    case (step)
      2'd0:    return EXEC0;
      2'd1:    return EXEC1;
      2'd2:    return EXEC2;
      default: return EXEC3;
    endcase
  endfunction

  function automatic logic is_busy(input state_t s);
    case (s)
      FETCH0, FETCH1, FETCH2, EXEC0, EXEC1, EXEC2, EXEC3: return 1'b1;
      default:                                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_microrom.sv
// Combinational microcode: micro-op word for one execute step of an opcode,
// plus whether that step finishes the instruction.
module cu_microrom
  import cu_pkg::*;
#(
  parameter int OPC_W = 8
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [1:0]       step,
  input  logic             flag0,
  output logic [CW-1:0]    word,
  output logic             last
);

  logic [CW-1:0] op_word_s;

  // Single ALU-op selection; MPY is the only op that also drives MR.
  always_comb begin
    op_word_s = 32'h0;
    case (opcode)
      OPC_W'(OP_ADD): op_word_s = bit_word(B_ADD);
      OPC_W'(OP_SUB): op_word_s = bit_word(B_SUB);
      OPC_W'(OP_AND): op_word_s = bit_word(B_AND);
      OPC_W'(OP_OR):  op_word_s = bit_word(B_OR);
      OPC_W'(OP_MPY): op_word_s = bit_word(B_MPY_LO_ACC) | bit_word(B_MPY_HI_MR);
      OPC_W'(OP_NOT): op_word_s = bit_word(B_NOT);
      OPC_W'(OP_SHR): op_word_s = bit_word(B_SHR);
      OPC_W'(OP_SHL): op_word_s = bit_word(B_SHL);
      OPC_W'(OP_SAR): op_word_s = bit_word(B_SAR);
      OPC_W'(OP_SAL): op_word_s = bit_word(B_SAL);
      default:        op_word_s = 32'h0;
    endcase
  end

  // Step sequencing per instruction class; unknown opcodes are one-step NOPs.
  always_comb begin
    word = 32'h0;
    last = 1'b1;
    case (opcode)
      OPC_W'(OP_STORE): begin
        last = (step == 2'd2);
        case (step)
          2'd0:    word = bit_word(B_IRADDR_MAR);
          2'd1:    word = bit_word(B_ACC_MBR);
          2'd2:    word = bit_word(B_MBR_MEM);
          default: word = 32'h0;
        endcase
      end
      OPC_W'(OP_LOAD): begin
        last = (step == 2'd2);
        case (step)
          2'd0:    word = bit_word(B_IRADDR_MAR);
          2'd1:    word = bit_word(B_MEM_MBR);
          2'd2:    word = bit_word(B_MBR_BR) | bit_word(B_BR_ACC);
          default: word = 32'h0;
        endcase
      end
      OPC_W'(OP_ADD), OPC_W'(OP_SUB), OPC_W'(OP_AND), OPC_W'(OP_OR), OPC_W'(OP_MPY): begin
        last = (step == 2'd3);
        case (step)
          2'd0:    word = bit_word(B_IRADDR_MAR);
          2'd1:    word = bit_word(B_MEM_MBR);
          2'd2:    word = bit_word(B_MBR_BR);
          default: word = op_word_s;
        endcase
      end
      OPC_W'(OP_NOT), OPC_W'(OP_SHR), OPC_W'(OP_SHL), OPC_W'(OP_SAR), OPC_W'(OP_SAL): begin
        word = op_word_s;
      end
      OPC_W'(OP_JMP): begin
        word = bit_word(B_IRADDR_PC);
      end
      OPC_W'(OP_JMPGEZ): begin
        if (flag0) begin
          word = 32'h0;
        end else begin
          word = bit_word(B_IRADDR_PC);
        end
      end
      default: begin
        word = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Microprogrammed control unit: fetch/execute sequencer issuing one registered
// micro-op word per state.
module control_unit
  import cu_pkg::*;
#(
  parameter int OPC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPC_W-1:0] IRtoCU,
  input  logic [7:0]       flag,
  output logic [CW-1:0]    control_signal,
  output logic             busy,
  output logic             halted
);

  state_t           state_r;
  logic [OPC_W-1:0] opcode_r;
  logic             last_r;

  state_t           next_state_s;
  logic [CW-1:0]    next_word_s;
  logic [OPC_W-1:0] next_opcode_s;
  logic             next_last_s;
  logic [OPC_W-1:0] rom_opc_s;
  logic [1:0]       rom_step_s;
  logic [CW-1:0]    rom_word_s;
  logic             rom_last_s;
  logic             unused_flag_s;

  assign unused_flag_s = ^flag[7:1];

  cu_microrom #(.OPC_W(OPC_W)) u_microrom (
    .opcode (rom_opc_s),
    .step   (rom_step_s),
    .flag0  (flag[0]),
    .word   (rom_word_s),
    .last   (rom_last_s)
  );

  // Next state and the word for that state; the ROM is always queried for the
  // step about to be entered, using the live opcode only on the FETCH2 edge.
  always_comb begin
    next_state_s  = state_r;
    next_word_s   = 32'h0;
    next_opcode_s = opcode_r;
    next_last_s   = last_r;
    rom_opc_s     = opcode_r;
    rom_step_s    = step_of(state_r) + 2'd1;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = FETCH0;
          next_word_s  = W_FETCH0;
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH0: begin
        next_state_s = FETCH1;
        next_word_s  = W_FETCH1;
      end
      FETCH1: begin
        next_state_s = FETCH2;
        next_word_s  = W_FETCH2;
      end
      FETCH2: begin
        rom_opc_s     = IRtoCU;
        rom_step_s    = 2'd0;
        next_opcode_s = IRtoCU;
        if (IRtoCU == OPC_W'(OP_HALT)) begin
          next_state_s = HALT;
          next_last_s  = 1'b1;
        end else begin
          next_state_s = EXEC0;
          next_word_s  = rom_word_s;
          next_last_s  = rom_last_s;
        end
      end
      EXEC0, EXEC1, EXEC2, EXEC3: begin
        if (last_r) begin
          next_state_s = FETCH0;
          next_word_s  = W_FETCH0;
        end else begin
          next_state_s = exec_state(rom_step_s);
          next_word_s  = rom_word_s;
          next_last_s  = rom_last_s;
        end
      end
      HALT: begin
        next_state_s = HALT;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, latched opcode and all outputs update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= IDLE;
      opcode_r       <= '0;
      last_r         <= 1'b0;
      control_signal <= 32'h0;
      busy           <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state_r        <= next_state_s;
      opcode_r       <= next_opcode_s;
      last_r         <= next_last_s;
      control_signal <= next_word_s;
      busy           <= is_busy(next_state_s);
      halted         <= (next_state_s == HALT);
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed table-driven bench for control_unit with hand-computed micro-op words.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  IRtoCU;
  logic [7:0]  flag;
  logic [31:0] control_signal;
  logic        busy;
  logic        halted;

  always #5 clk = ~clk;

  control_unit #(.OPC_W(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .IRtoCU         (IRtoCU),
    .flag           (flag),
    .control_signal (control_signal),
    .busy           (busy),
    .halted         (halted)
  );

  typedef struct {
    logic [7:0]        opc;
    logic [7:0]        flg;
    int                n;
    logic [3:0][31:0]  w;
  } vec_t;

  vec_t tbl [19];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkv(input logic [7:0] opc, input logic [7:0] flg, input int n,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
    vec_t v;
    v.opc  = opc;
    v.flg  = flg;
    v.n    = n;
    v.w[0] = w0;
    v.w[1] = w1;
    v.w[2] = w2;
    v.w[3] = w3;
    return v;
  endfunction

  // Entered with the DUT in FETCH0; leaves it in the following FETCH0.
  task automatic run_instr(input vec_t v);
    IRtoCU = v.opc;
    flag   = v.flg;
    tick;
    chk("fetch1", control_signal, 32'h0000_0006);
    tick;
    chk("fetch2", control_signal, 32'h0000_0008);
    chk("fetch_busy", {31'b0, busy}, 32'h1);
    for (int k = 0; k < v.n; k++) begin
      tick;
      if (k == 0) begin
        IRtoCU = ~v.opc;
        flag   = ~v.flg;
      end
      chk($sformatf("op%02h_f%02h_exec%0d", v.opc, v.flg, k), control_signal, v.w[k]);
      chk($sformatf("op%02h_exec%0d_busy", v.opc, k), {31'b0, busy}, 32'h1);
    end
    tick;
    chk($sformatf("op%02h_return_fetch0", v.opc), control_signal, 32'h0000_0001);
  endtask

  initial begin
    tbl[0]  = mkv(8'h01, 8'h00, 3, 32'h10, 32'h40, 32'h80, 32'h0);
    tbl[1]  = mkv(8'h02, 8'h00, 3, 32'h10, 32'h04, 32'h220, 32'h0);
    tbl[2]  = mkv(8'h03, 8'h00, 4, 32'h10, 32'h04, 32'h20, 32'h0040_0000);
    tbl[3]  = mkv(8'h04, 8'h00, 4, 32'h10, 32'h04, 32'h20, 32'h0080_0000);
    tbl[4]  = mkv(8'h08, 8'h00, 4, 32'h10, 32'h04, 32'h20, 32'h2001_0000);
    tbl[5]  = mkv(8'h0A, 8'h00, 4, 32'h10, 32'h04, 32'h20, 32'h0100_0000);
    tbl[6]  = mkv(8'h0B, 8'h00, 4, 32'h10, 32'h04, 32'h20, 32'h0200_0000);
    tbl[7]  = mkv(8'h0C, 8'h00, 1, 32'h0400_0000, 32'h0, 32'h0, 32'h0);
    tbl[8]  = mkv(8'h0D, 8'h00, 1, 32'h1000_0000, 32'h0, 32'h0, 32'h0);
    tbl[9]  = mkv(8'h0E, 8'h00, 1, 32'h0800_0000, 32'h0, 32'h0, 32'h0);
    tbl[10] = mkv(8'h0F, 8'h00, 1, 32'h8000_0000, 32'h0, 32'h0, 32'h0);
    tbl[11] = mkv(8'h10, 8'h00, 1, 32'h4000_0000, 32'h0, 32'h0, 32'h0);
    tbl[12] = mkv(8'h06, 8'h01, 1, 32'h100, 32'h0, 32'h0, 32'h0);
    tbl[13] = mkv(8'h05, 8'h00, 1, 32'h100, 32'h0, 32'h0, 32'h0);
    tbl[14] = mkv(8'h05, 8'h01, 1, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[15] = mkv(8'h05, 8'hFE, 1, 32'h100, 32'h0, 32'h0, 32'h0);
    tbl[16] = mkv(8'hFF, 8'h00, 1, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[17] = mkv(8'h00, 8'h00, 1, 32'h0, 32'h0, 32'h0, 32'h0);
    tbl[18] = mkv(8'h09, 8'h00, 1, 32'h0, 32'h0, 32'h0, 32'h0);

    rst    = 1'b0;
    start  = 1'b0;
    IRtoCU = 8'h00;
    flag   = 8'h00;
    #2;
    chk("reset_word", control_signal, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_halted", {31'b0, halted}, 32'h0);
    tick;
    rst = 1'b1;
    tick;
    chk("idle_hold_word", control_signal, 32'h0);
    chk("idle_hold_busy", {31'b0, busy}, 32'h0);
    start = 1'b1;
    tick;
    chk("first_fetch0", control_signal, 32'h0000_0001);
    chk("first_fetch0_busy", {31'b0, busy}, 32'h1);

    for (int i = 0; i < 19; i++) begin
      run_instr(tbl[i]);
    end

    // HALT: sticky, no micro-ops, start ignored.
    IRtoCU = 8'h07;
    tick;
    chk("halt_fetch1", control_signal, 32'h6);
    tick;
    chk("halt_fetch2", control_signal, 32'h8);
    tick;
    chk("halt_word", control_signal, 32'h0);
    chk("halt_flag", {31'b0, halted}, 32'h1);
    chk("halt_busy", {31'b0, busy}, 32'h0);
    for (int c = 0; c < 20; c++) begin
      start = ~start;
      tick;
      chk($sformatf("halt_hold_word_%0d", c), control_signal, 32'h0);
      chk($sformatf("halt_hold_flag_%0d", c), {31'b0, halted}, 32'h1);
    end

    // Reset out of HALT, then reset in the middle of a LOAD.
    rst = 1'b0;
    #1;
    chk("halt_reset_halted", {31'b0, halted}, 32'h0);
    tick;
    rst   = 1'b1;
    start = 1'b1;
    tick;
    chk("restart_fetch0", control_signal, 32'h1);
    IRtoCU = 8'h02;
    tick;
    tick;
    tick;
    chk("load_exec0", control_signal, 32'h10);
    tick;
    chk("load_exec1", control_signal, 32'h04);
    #2;
    rst = 1'b0;
    #1;
    chk("midload_reset_word", control_signal, 32'h0);
    chk("midload_reset_busy", {31'b0, busy}, 32'h0);
    start = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    chk("post_reset_idle_word", control_signal, 32'h0);
    chk("post_reset_idle_busy", {31'b0, busy}, 32'h0);
    tick;
    chk("post_reset_idle_word2", control_signal, 32'h0);
    start = 1'b1;
    tick;
    chk("post_reset_fetch0", control_signal, 32'h1);
    run_instr(mkv(8'hFF, 8'h00, 1, 32'h0, 32'h0, 32'h0, 32'h0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
